// File: rtl/ex_mem_stage_rvs192_pkg.sv
`default_nettype none
// ============================================================================
// Module   : RVS192_package
// Purpose  : Shared types and constants for the RVS192 EX/MEM stage.
//            Holds the EX-to-MEM control bundle and the conditional-branch
//            funct3 encodings.
// Revision : 1.0 - initial release
// ============================================================================
package RVS192_package;

  // Control bundle carried from EX into MEM alongside the datapath values
  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_size;
  } ex_ctrl_t;

  // Conditional branch funct3 encodings
  localparam logic [2:0] c_F3_BEQ  = 3'b000;
  localparam logic [2:0] c_F3_BNE  = 3'b001;
  localparam logic [2:0] c_F3_BLT  = 3'b100;
  localparam logic [2:0] c_F3_BGE  = 3'b101;
  localparam logic [2:0] c_F3_BLTU = 3'b110;
  localparam logic [2:0] c_F3_BGEU = 3'b111;

endpackage
`default_nettype wire

// File: rtl/ex_mem_stage_rvs192_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_rvs192
// Purpose  : Combinational taken/target resolution for branches and jumps.
//            Uses the ALU eq/ge flags; signedness is already chosen upstream.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_rvs192
  import RVS192_package::*;
#(
  parameter int DATA_LENGTH = 32
) (
  input  logic                   branch_capture,
  input  logic [2:0]             br_funct3,
  input  logic                   jal,
  input  logic                   jalr,
  input  logic                   eq,
  input  logic                   ge,
  input  logic [DATA_LENGTH-1:0] target_pc,
  output logic                   taken,
  output logic [DATA_LENGTH-1:0] target
);

  logic w_cond_taken;

  // Decode the conditional-branch outcome from funct3 and the ALU flags
  always_comb begin
    w_cond_taken = 1'b0;
    case (br_funct3)
      c_F3_BEQ:             w_cond_taken = eq;
      c_F3_BNE:             w_cond_taken = !eq;
      c_F3_BLT, c_F3_BLTU:  w_cond_taken = !ge;
      c_F3_BGE, c_F3_BGEU:  w_cond_taken = ge;
      default:              w_cond_taken = 1'b0;
    endcase
  end

  // Jumps are unconditional; jalr clears the LSB of the computed target
  always_comb begin
    taken  = jal || jalr || (branch_capture && w_cond_taken);
    target = target_pc;
    if (jalr) target[0] = 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/ex_mem_stage_rvs192.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage_rvs192
// Purpose  : EX/MEM pipeline register with valid/ready handshake, branch and
//            jump resolution, one-cycle fetch redirect and a fixed-length
//            wrong-path squash (FLUSH) window.
// Options  : RVS192_BR_MISALIGN_CHECK_EN - turns a taken branch/jump whose
//            target has bit 1 set into a misalign_exc pulse instead of a
//            redirect (the flush window still runs).
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_stage_rvs192
  import RVS192_package::*;
#(
  parameter int DATA_LENGTH = 32,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ex_valid,
  output logic                   ex_ready,
  input  ex_ctrl_t               ex_ctrl,
  input  logic [DATA_LENGTH-1:0] alu_out,
  input  logic [DATA_LENGTH-1:0] store_data_ex,
  input  logic [DATA_LENGTH-1:0] target_pc,
  input  logic                   eq,
  input  logic                   ge,
  input  logic                   branch_capture,
  input  logic [2:0]             br_funct3,
  input  logic                   jal,
  input  logic                   jalr,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output ex_ctrl_t               mem_ctrl,
  output logic [DATA_LENGTH-1:0] mem_alu_out,
  output logic [DATA_LENGTH-1:0] mem_store_data,
  output logic                   redirect_valid,
  output logic [DATA_LENGTH-1:0] redirect_pc,
  output logic                   flush_if_id,
  output logic                   misalign_exc
);

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  localparam logic [2:0] c_FLUSH_DEPTH = 3'(FLUSH_DEPTH);

  state_t                   state_q;
  logic [2:0]               cnt_q;
  logic                     mem_valid_q;
  ex_ctrl_t                 mem_ctrl_q;
  ex_ctrl_t                 mem_ctrl_d;
  logic [DATA_LENGTH-1:0]   mem_alu_out_q;
  logic [DATA_LENGTH-1:0]   mem_store_data_q;
  logic                     redirect_valid_q;
  logic [DATA_LENGTH-1:0]   redirect_pc_q;
  logic                     flush_if_id_q;
  logic                     misalign_exc_q;

  logic                     w_taken;
  logic [DATA_LENGTH-1:0]   w_target;
  logic                     w_run_accept;
  logic                     w_take_accept;
  logic                     w_issue_redirect;
  logic                     w_issue_misalign;

  branch_resolve_rvs192 #(
    .DATA_LENGTH (DATA_LENGTH)
  ) u_branch_resolve (
    .branch_capture (branch_capture),
    .br_funct3      (br_funct3),
    .jal            (jal),
    .jalr           (jalr),
    .eq             (eq),
    .ge             (ge),
    .target_pc      (target_pc),
    .taken          (w_taken),
    .target         (w_target)
  );

  // Handshake: FLUSH always drains EX; RUN accepts when MEM has room
  always_comb begin
    ex_ready      = (state_q == S_FLUSH) ? 1'b1 : (!mem_valid_q || mem_ready);
    w_run_accept  = (state_q == S_RUN) && ex_valid && ex_ready;
    w_take_accept = w_run_accept && w_taken;
`ifdef RVS192_BR_MISALIGN_CHECK_EN
    w_issue_misalign = w_take_accept && w_target[1];
    w_issue_redirect = w_take_accept && !w_target[1];
`else
    w_issue_misalign = 1'b0;
    w_issue_redirect = w_take_accept;
`endif
  end

  // Conditional branches never write back; jumps keep reg_write for the link
  always_comb begin
    mem_ctrl_d = ex_ctrl;
    if (branch_capture && !jal && !jalr) mem_ctrl_d.reg_write = 1'b0;
  end

  // Pipeline register, redirect/exception pulses and RUN/FLUSH control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_RUN;
      cnt_q            <= 3'd0;
      mem_valid_q      <= 1'b0;
      mem_ctrl_q       <= '0;
      mem_alu_out_q    <= '0;
      mem_store_data_q <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_if_id_q    <= 1'b0;
      misalign_exc_q   <= 1'b0;
    end else begin
      redirect_valid_q <= w_issue_redirect;
      misalign_exc_q   <= w_issue_misalign;
      if (w_issue_redirect) redirect_pc_q <= w_target;

      if (w_run_accept) begin
        mem_valid_q      <= 1'b1;
        mem_ctrl_q       <= mem_ctrl_d;
        mem_alu_out_q    <= alu_out;
        mem_store_data_q <= store_data_ex;
      end else if (mem_ready) begin
        mem_valid_q      <= 1'b0;
      end

      case (state_q)
        S_RUN: begin
          if (w_take_accept) begin
            state_q       <= S_FLUSH;
            cnt_q         <= c_FLUSH_DEPTH;
            flush_if_id_q <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (cnt_q <= 3'd1) begin
            state_q       <= S_RUN;
            cnt_q         <= 3'd0;
            flush_if_id_q <= 1'b0;
          end else begin
            cnt_q         <= cnt_q - 3'd1;
          end
        end
        default: begin
          state_q       <= S_RUN;
          cnt_q         <= 3'd0;
          flush_if_id_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_valid      = mem_valid_q;
  assign mem_ctrl       = mem_ctrl_q;
  assign mem_alu_out    = mem_alu_out_q;
  assign mem_store_data = mem_store_data_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush_if_id    = flush_if_id_q;
`ifdef RVS192_BR_MISALIGN_CHECK_EN
  assign misalign_exc   = misalign_exc_q;
`else
  assign misalign_exc   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage_rvs192.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_stage_rvs192
// Purpose  : Directed self-checking bench for ex_mem_stage_rvs192.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage_rvs192;
  import RVS192_package::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  ex_ctrl_t    ex_ctrl;
  logic [31:0] alu_out;
  logic [31:0] store_data_ex;
  logic [31:0] target_pc;
  logic        eq;
  logic        ge;
  logic        branch_capture;
  logic [2:0]  br_funct3;
  logic        jal;
  logic        jalr;
  logic        mem_valid;
  logic        mem_ready;
  ex_ctrl_t    mem_ctrl;
  logic [31:0] mem_alu_out;
  logic [31:0] mem_store_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_if_id;
  logic        misalign_exc;

  int checks   = 0;
  int failures = 0;

  ex_mem_stage_rvs192 #(.DATA_LENGTH(32), .FLUSH_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_ctrl        (ex_ctrl),
    .alu_out        (alu_out),
    .store_data_ex  (store_data_ex),
    .target_pc      (target_pc),
    .eq             (eq),
    .ge             (ge),
    .branch_capture (branch_capture),
    .br_funct3      (br_funct3),
    .jal            (jal),
    .jalr           (jalr),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_ctrl       (mem_ctrl),
    .mem_alu_out    (mem_alu_out),
    .mem_store_data (mem_store_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_if_id    (flush_if_id),
    .misalign_exc   (misalign_exc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One active edge, then settle on the following falling edge for sampling
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input logic v, input logic [4:0] rd, input logic rw,
                        input logic [31:0] alu, input logic [31:0] sd);
    ex_valid          = v;
    ex_ctrl           = '0;
    ex_ctrl.rd        = rd;
    ex_ctrl.reg_write = rw;
    alu_out           = alu;
    store_data_ex     = sd;
    branch_capture    = 1'b0;
    br_funct3         = 3'b000;
    jal               = 1'b0;
    jalr              = 1'b0;
    eq                = 1'b0;
    ge                = 1'b0;
    target_pc         = 32'h0;
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    set_op(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();

    // Reset state
    check("rst_mem_valid", 32'(mem_valid), 32'h0);
    check("rst_ex_ready", 32'(ex_ready), 32'h1);
    check("rst_redirect", 32'(redirect_valid), 32'h0);
    check("rst_flush", 32'(flush_if_id), 32'h0);
    check("rst_alu_out", mem_alu_out, 32'h0);
    check("rst_misalign", 32'(misalign_exc), 32'h0);
    rst_n = 1'b1;

    // Back-to-back ADDs
    set_op(1'b1, 5'd1, 1'b1, 32'd5, 32'hA5);
    tick();
    check("add1_valid", 32'(mem_valid), 32'h1);
    check("add1_alu", mem_alu_out, 32'd5);
    check("add1_sd", mem_store_data, 32'hA5);
    set_op(1'b1, 5'd1, 1'b1, 32'd7, 32'hA7);
    tick();
    check("add2_valid", 32'(mem_valid), 32'h1);
    check("add2_alu", mem_alu_out, 32'd7);

    // MEM stall for three cycles; new EX op must wait
    set_op(1'b1, 5'd2, 1'b1, 32'd9, 32'h0);
    mem_ready = 1'b0;
    #1;
    check("stall_ex_ready", 32'(ex_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_alu", mem_alu_out, 32'd7);
      check("stall_rd", 32'(mem_ctrl.rd), 32'd1);
      check("stall_valid", 32'(mem_valid), 32'h1);
    end
    mem_ready = 1'b1;
    #1;
    check("unstall_ex_ready", 32'(ex_ready), 32'h1);
    tick();
    check("unstall_alu", mem_alu_out, 32'd9);
    check("unstall_rd", 32'(mem_ctrl.rd), 32'd2);

    // Bubble drains MEM
    set_op(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    tick();
    check("drain_valid", 32'(mem_valid), 32'h0);

    // Taken BNE -> redirect 0x100, two-cycle flush
    set_op(1'b1, 5'd3, 1'b1, 32'h44, 32'h0);
    branch_capture = 1'b1;
    br_funct3      = 3'b001;
    eq             = 1'b0;
    target_pc      = 32'h100;
    tick();
    check("bne_redirect", 32'(redirect_valid), 32'h1);
    check("bne_redirect_pc", redirect_pc, 32'h100);
    check("bne_flush1", 32'(flush_if_id), 32'h1);
    check("bne_mem_valid", 32'(mem_valid), 32'h1);
    check("bne_mem_alu", mem_alu_out, 32'h44);
    check("bne_reg_write", 32'(mem_ctrl.reg_write), 32'h0);

    // First wrong-path op is dropped
    set_op(1'b1, 5'd4, 1'b1, 32'h11, 32'h0);
    #1;
    check("flush_ex_ready", 32'(ex_ready), 32'h1);
    tick();
    check("drop1_redirect", 32'(redirect_valid), 32'h0);
    check("drop1_flush2", 32'(flush_if_id), 32'h1);
    check("drop1_mem_valid", 32'(mem_valid), 32'h0);

    // Taken BEQ during flush is discarded
    set_op(1'b1, 5'd5, 1'b0, 32'h22, 32'h0);
    branch_capture = 1'b1;
    br_funct3      = 3'b000;
    eq             = 1'b1;
    target_pc      = 32'h300;
    tick();
    check("beq_flush_redirect", 32'(redirect_valid), 32'h0);
    check("beq_flush_end", 32'(flush_if_id), 32'h0);
    check("beq_flush_mem_valid", 32'(mem_valid), 32'h0);
    set_op(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    tick();
    check("post_flush_redirect", 32'(redirect_valid), 32'h0);
    check("post_flush_flush", 32'(flush_if_id), 32'h0);

    // Not-taken BGE enters MEM without write-back
    set_op(1'b1, 5'd6, 1'b1, 32'h55, 32'h0);
    branch_capture = 1'b1;
    br_funct3      = 3'b101;
    ge             = 1'b0;
    target_pc      = 32'h400;
    tick();
    check("bge_redirect", 32'(redirect_valid), 32'h0);
    check("bge_flush", 32'(flush_if_id), 32'h0);
    check("bge_mem_valid", 32'(mem_valid), 32'h1);
    check("bge_mem_alu", mem_alu_out, 32'h55);
    check("bge_reg_write", 32'(mem_ctrl.reg_write), 32'h0);

    // funct3 010 is never taken, even with flags set
    set_op(1'b1, 5'd7, 1'b0, 32'h66, 32'h0);
    branch_capture = 1'b1;
    br_funct3      = 3'b010;
    eq             = 1'b1;
    ge             = 1'b1;
    target_pc      = 32'h404;
    tick();
    check("f3_010_redirect", 32'(redirect_valid), 32'h0);
    check("f3_010_flush", 32'(flush_if_id), 32'h0);

    // JALR with target 0x203
    set_op(1'b1, 5'd1, 1'b1, 32'h88, 32'h0);
    jalr      = 1'b1;
    target_pc = 32'h203;
    tick();
    check("jalr_mem_alu", mem_alu_out, 32'h88);
    check("jalr_reg_write", 32'(mem_ctrl.reg_write), 32'h1);
    check("jalr_flush", 32'(flush_if_id), 32'h1);
`ifdef RVS192_BR_MISALIGN_CHECK_EN
    check("jalr_redirect", 32'(redirect_valid), 32'h0);
    check("jalr_misalign", 32'(misalign_exc), 32'h1);
`else
    check("jalr_redirect", 32'(redirect_valid), 32'h1);
    check("jalr_redirect_pc", redirect_pc, 32'h202);
    check("jalr_misalign", 32'(misalign_exc), 32'h0);
`endif
    set_op(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    tick();
    check("jalr_pulse_end", 32'(redirect_valid), 32'h0);
    check("jalr_misalign_end", 32'(misalign_exc), 32'h0);
    check("jalr_flush2", 32'(flush_if_id), 32'h1);
    tick();
    check("jalr_flush_end", 32'(flush_if_id), 32'h0);

    // Taken BLTU (ge=0) then asynchronous reset mid-flush
    set_op(1'b1, 5'd2, 1'b1, 32'h99, 32'h0);
    branch_capture = 1'b1;
    br_funct3      = 3'b110;
    ge             = 1'b0;
    target_pc      = 32'h600;
    tick();
    check("bltu_redirect", 32'(redirect_valid), 32'h1);
    check("bltu_redirect_pc", redirect_pc, 32'h600);
    check("bltu_flush", 32'(flush_if_id), 32'h1);
    set_op(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    check("arst_flush", 32'(flush_if_id), 32'h0);
    check("arst_redirect", 32'(redirect_valid), 32'h0);
    check("arst_redirect_pc", redirect_pc, 32'h0);
    check("arst_mem_valid", 32'(mem_valid), 32'h0);
    check("arst_mem_alu", mem_alu_out, 32'h0);
    tick();
    rst_n = 1'b1;
    set_op(1'b1, 5'd3, 1'b1, 32'h77, 32'h0);
    tick();
    check("post_rst_valid", 32'(mem_valid), 32'h1);
    check("post_rst_alu", mem_alu_out, 32'h77);
    check("post_rst_flush", 32'(flush_if_id), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_mem_stage_rvs192.md
# ex_mem_stage_rvs192
EX/MEM pipeline stage of the RVS192 core, directly downstream of the ALU. It registers the ALU result, store data and control bundle into the MEM stage under a valid/ready handshake. It resolves conditional branches and jumps from the ALU's `eq`, `ge` and `target_pc` outputs. On a taken branch it issues a one-cycle fetch redirect and squashes wrong-path instructions for a fixed number of cycles.
## Interface
- `DATA_LENGTH`, 32: datapath width.
- `FLUSH_DEPTH`, 2: cycles of wrong-path squash after a redirect (range 1..7).
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: EX holds an instruction.
- `ex_ready` out 1: stage accepts the EX instruction this cycle.
- `ex_ctrl` in `ex_ctrl_t`: rd, reg_write, mem_read, mem_write, mem_size.
- `alu_out` in DATA_LENGTH: ALU result (link address for jal/jalr).
- `store_data_ex` in DATA_LENGTH: rs2 value for stores.
- `target_pc` in DATA_LENGTH: branch/jump target from the ALU adder.
- `eq` in 1: ALU equality flag.
- `ge` in 1: ALU greater-or-equal flag. Upstream already selects signed or unsigned compare through `alu_op`.
- `branch_capture` in 1: conditional branch in EX.
- `br_funct3` in 3: branch funct3.
- `jal` in 1: unconditional jump in EX.
- `jalr` in 1: register-indirect jump in EX.
- `mem_valid` out 1: MEM register holds an instruction.
- `mem_ready` in 1: MEM consumes this cycle.
- `mem_ctrl` out `ex_ctrl_t`: registered control bundle.
- `mem_alu_out` out DATA_LENGTH: registered ALU result.
- `mem_store_data` out DATA_LENGTH: registered store data.
- `redirect_valid` out 1: one-cycle fetch redirect.
- `redirect_pc` out DATA_LENGTH: redirect target.
- `flush_if_id` out 1: squash IF/ID contents.
- `misalign_exc` out 1: target misaligned (see Configuration).
## Operation
- `ex_ready` = `!mem_valid || mem_ready`.
- A handshake is accepted when `ex_valid && ex_ready`.
- State machine:
  - RUN: accepted instructions load the MEM register. On an accepted taken branch or jump, go to FLUSH with `cnt = FLUSH_DEPTH`.
  - FLUSH: `ex_ready` = 1. Any `ex_valid` is discarded and produces no MEM entry and no redirect, including taken branches. `cnt` decrements each cycle. Return to RUN when `cnt` reaches 1.
- Taken decision (conditional branch):
  - BEQ 000 → `eq`.
  - BNE 001 → `!eq`.
  - BLT 100 and BLTU 110 → `!ge`.
  - BGE 101 and BGEU 111 → `ge`.
  - funct3 010 and 011 → not taken.
- `jal` and `jalr` are always taken.
- `redirect_pc` = `target_pc`; for `jalr`, bit 0 is forced to 0.
- Conditional branches enter MEM with reg_write = 0. jal/jalr enter MEM with `alu_out` as link data.
- MEM register: loaded on an accepted RUN handshake. `mem_valid` clears on `mem_ready` without a new load. Held unchanged while `mem_valid && !mem_ready`.
## Timing
- Reset values: all outputs 0, state = RUN, `cnt` = 0. Reset asserted mid-FLUSH aborts the flush immediately.
- Latency is 1 cycle, EX handshake to `mem_valid`. With `mem_ready` held high, one instruction per cycle.
- Taken branch accepted at edge N:
  - `redirect_valid` is high in the cycle after N, for exactly one cycle.
  - `flush_if_id` is high for FLUSH_DEPTH cycles starting in that same cycle.
- Redirect is issued at acceptance, independent of later `mem_ready`. A MEM stall stalls EX but never delays an already-issued redirect.
- Not-taken branches produce no redirect and no flush.
## Configuration
- Macro: `RVS192_BR_MISALIGN_CHECK_EN`.
- Defined:
  - Applies to a taken branch or jump whose `target_pc[1]` = 1 (bit 0 ignored for jalr).
  - `redirect_valid` is suppressed.
  - `misalign_exc` pulses for one cycle, with the same timing the redirect would have had.
  - The flush still runs.
- Undefined: `misalign_exc` is tied to 0 and the redirect is always issued.
## Structure
- `ex_ctrl_t` (rd[4:0], reg_write, mem_read, mem_write, mem_size[2:0]) and the branch funct3 localparams go in `RVS192_package`.
- One sub-module, `branch_resolve_rvs192`: purely combinational taken/target logic, instantiated once.
## Test plan
- Back-to-back ADDs, `mem_ready` = 1, `alu_out` 5 then 7 → `mem_alu_out` 5 then 7 on consecutive cycles, `mem_valid` continuous.
- `mem_ready` = 0 for 3 cycles with `mem_valid` = 1 → `ex_ready` = 0; `mem_alu_out` and `mem_ctrl` stable; `ex_valid` data is accepted only after `mem_ready` rises.
- BNE, `eq` = 0, `target_pc` 0x100, FLUSH_DEPTH = 2 → `redirect_valid` for 1 cycle with `redirect_pc` 0x100, `flush_if_id` high for 2 cycles, next 2 `ex_valid` instructions dropped.
- BGE with `ge` = 0 → no redirect, branch enters MEM with reg_write = 0. Then JALR with `target_pc` 0x203 → `redirect_pc` 0x202 when the macro is off; `misalign_exc` = 1 and no redirect when the macro is on.
- Taken BEQ arriving during FLUSH → discarded, no second redirect.
- `rst_n` low mid-FLUSH → all outputs 0 asynchronously; next `ex_valid` after release is accepted.
